// File: rtl/pe_dma_pkg.sv
// Shared definitions for the multi-channel transmit DMA.
// Contents:
//   dma_state_e - FSM states of the transfer engine.
//   flit_ratio  - number of flits carried by one memory word.
//   idx_w       - width of an index into n items, never less than 1.
// The descriptor struct is declared inside pe_dma_mc because its field
// widths follow that module's parameters.
package pe_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        READ,
        WAIT,
        SEND,
        DONE
    } dma_state_e;

    function automatic int flit_ratio(input int bus_w, input int flit_w);
        return bus_w / flit_w;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_dma_mc_if.sv
// Bundle of the DMA's configuration, status, memory-read and flit-link signals.
// Modports:
//   master - the DMA side. It drives cfg_err, ch_busy, ch_done, mem_rd_en,
//            mem_addr, flit_out and flit_valid.
//   slave  - the environment side (CPU, local memory, router). It drives
//            cfg_*, done_clr, mem_rdata and flit_ready.
interface pe_dma_mc_if
    import pe_dma_pkg::*;
#(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int FLIT_WIDTH       = 16,
    parameter int NUM_CHANNELS     = 4,
    parameter int LEN_WIDTH        = 16
);
    localparam int CW = idx_w(NUM_CHANNELS);

    logic                        cfg_we;
    logic [CW-1:0]               cfg_chan;
    logic [MEMORY_BUS_WIDTH-1:0] cfg_addr;
    logic [LEN_WIDTH-1:0]        cfg_len;
    logic                        cfg_err;
    logic [NUM_CHANNELS-1:0]     ch_busy;
    logic [NUM_CHANNELS-1:0]     ch_done;
    logic [NUM_CHANNELS-1:0]     done_clr;
    logic                        mem_rd_en;
    logic [MEMORY_BUS_WIDTH-1:0] mem_addr;
    logic [MEMORY_BUS_WIDTH-1:0] mem_rdata;
    logic [FLIT_WIDTH-1:0]       flit_out;
    logic                        flit_valid;
    logic                        flit_ready;

    modport master (
        input  cfg_we, cfg_chan, cfg_addr, cfg_len, done_clr, mem_rdata, flit_ready,
        output cfg_err, ch_busy, ch_done, mem_rd_en, mem_addr, flit_out, flit_valid
    );

    modport slave (
        output cfg_we, cfg_chan, cfg_addr, cfg_len, done_clr, mem_rdata, flit_ready,
        input  cfg_err, ch_busy, ch_done, mem_rd_en, mem_addr, flit_out, flit_valid
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req   in  NUM_CHANNELS  request vector (channels holding a descriptor)
//   ptr   in  idx_w(N)      highest-priority channel index
//   grant out NUM_CHANNELS  one-hot grant, all zero when req is zero
// The winner is the first requester at or after ptr, wrapping to channel 0.
module rr_arbiter
    import pe_dma_pkg::*;
#(
    parameter int NUM_CHANNELS = 4
) (
    input  logic [NUM_CHANNELS-1:0]         req,
    input  logic [idx_w(NUM_CHANNELS)-1:0]  ptr,
    output logic [NUM_CHANNELS-1:0]         grant
);
    localparam logic [NUM_CHANNELS-1:0] ONE = {{(NUM_CHANNELS-1){1'b0}}, 1'b1};

    logic [NUM_CHANNELS-1:0] mask;
    logic [NUM_CHANNELS-1:0] masked;

    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        masked = req & mask;
        // x & -x isolates the lowest set bit; fall back to the unmasked
        // vector when nothing sits at or above the pointer (wrap-around).
        if (masked != '0) begin
            grant = masked & (~masked + ONE);
        end else begin
            grant = req & (~req + ONE);
        end
    end

endmodule

// File: rtl/pe_dma_mc.sv
// Multi-channel transmit DMA. The CPU queues one descriptor (start word
// address, length in flits) per channel; channels are served one packet at a
// time in round-robin order. Each memory word is split into RATIO flits,
// least-significant slice first, and sent on a valid/ready link.
// Ports:
//   clock - system clock
//   reset - asynchronous, active-low reset
//   bus   - pe_dma_mc_if.master: configuration, status, memory read port
//           and router flit link
module pe_dma_mc
    import pe_dma_pkg::*;
#(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int FLIT_WIDTH       = 16,
    parameter int NUM_CHANNELS     = 4,
    parameter int LEN_WIDTH        = 16
) (
    input  logic        clock,
    input  logic        reset,
    pe_dma_mc_if.master bus
);
    localparam int RATIO = flit_ratio(MEMORY_BUS_WIDTH, FLIT_WIDTH);
    localparam int CW    = idx_w(NUM_CHANNELS);
    localparam int SW    = idx_w(RATIO);
    localparam logic [SW-1:0] SLICE_LAST = SW'(RATIO - 1);

    typedef struct packed {
        logic [MEMORY_BUS_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]        len;
    } desc_t;

    dma_state_e state, state_nx;

    desc_t desc [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0] ch_busy, ch_done, busy_nx, done_nx;
    logic [NUM_CHANNELS-1:0] cfg_sel, busy_set, busy_clr, done_set, desc_we;
    logic [NUM_CHANNELS-1:0] gnt_onehot, grant_oh;
    logic                    cfg_err, err_nx;
    logic [CW-1:0]           rr_ptr, grant_idx, gnt_idx;

    logic [MEMORY_BUS_WIDTH-1:0] cur_addr;
    logic [MEMORY_BUS_WIDTH-1:0] shreg;
    logic [LEN_WIDTH-1:0]        remaining;
    logic [SW-1:0]               slice;

    logic xfer, last_flit, word_end;

    rr_arbiter #(
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_arb (
        .req   (ch_busy),
        .ptr   (rr_ptr),
        .grant (gnt_onehot)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (gnt_onehot[i]) gnt_idx = CW'(i);
        end
    end

    assign xfer      = (state == SEND) && bus.flit_ready;
    assign last_flit = (remaining == LEN_WIDTH'(1));
    assign word_end  = (slice == SLICE_LAST);

    // Descriptor bookkeeping. An out-of-range channel number decodes to no
    // channel and is rejected like a write to a busy channel. A completion
    // set always beats a done_clr in the same cycle.
    always_comb begin
        cfg_sel = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            cfg_sel[i] = (bus.cfg_chan == CW'(i));
        end
        busy_set = '0;
        busy_clr = '0;
        done_set = '0;
        desc_we  = '0;
        err_nx   = 1'b0;
        if (bus.cfg_we) begin
            if ((cfg_sel & ch_busy) != '0 || cfg_sel == '0) begin
                err_nx = 1'b1;
            end else if (bus.cfg_len == '0) begin
                done_set = cfg_sel;
            end else begin
                busy_set = cfg_sel;
                desc_we  = cfg_sel;
            end
        end
        if (state == DONE) begin
            busy_clr = grant_oh;
            done_set = done_set | grant_oh;
        end
        busy_nx = (ch_busy & ~busy_clr) | busy_set;
        done_nx = (ch_done & ~bus.done_clr) | done_set;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ch_busy != '0) state_nx = ARB;
            ARB:     state_nx = READ;
            READ:    state_nx = WAIT;
            WAIT:    state_nx = SEND;
            SEND: begin
                if (xfer) begin
                    if (last_flit)     state_nx = DONE;
                    else if (word_end) state_nx = READ;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ch_busy   <= '0;
            ch_done   <= '0;
            cfg_err   <= 1'b0;
            rr_ptr    <= '0;
            grant_idx <= '0;
            grant_oh  <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            slice     <= '0;
            shreg     <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                desc[i] <= '0;
            end
        end else begin
            state   <= state_nx;
            ch_busy <= busy_nx;
            ch_done <= done_nx;
            cfg_err <= err_nx;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (desc_we[i]) begin
                    desc[i].addr <= bus.cfg_addr;
                    desc[i].len  <= bus.cfg_len;
                end
            end
            case (state)
                ARB: begin
                    grant_idx <= gnt_idx;
                    grant_oh  <= gnt_onehot;
                    cur_addr  <= desc[gnt_idx].addr;
                    remaining <= desc[gnt_idx].len;
                end
                WAIT: begin
                    shreg <= bus.mem_rdata;
                    slice <= '0;
                end
                SEND: begin
                    // The low slice of shreg is always the flit on the link;
                    // shifting only on a transfer keeps it stable under stall.
                    if (xfer) begin
                        remaining <= remaining - 1'b1;
                        slice     <= slice + 1'b1;
                        shreg     <= shreg >> FLIT_WIDTH;
                        if (!last_flit && word_end) cur_addr <= cur_addr + 1'b1;
                    end
                end
                DONE: begin
                    rr_ptr <= (grant_idx == CW'(NUM_CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.cfg_err    = cfg_err;
    assign bus.ch_busy    = ch_busy;
    assign bus.ch_done    = ch_done;
    assign bus.mem_rd_en  = (state == READ);
    assign bus.mem_addr   = cur_addr;
    assign bus.flit_valid = (state == SEND);
    assign bus.flit_out   = shreg[FLIT_WIDTH-1:0];

endmodule

// File: tb/tb_pe_dma_mc.sv
module tb_pe_dma_mc;
    localparam int MW = 32;
    localparam int FW = 16;
    localparam int NC = 4;
    localparam int LW = 16;

    logic clock;
    logic reset;

    int checks   = 0;
    int failures = 0;
    int rd_cnt   = 0;
    int ready_mode = 0;   // 0: always ready, 1: toggle, 2: never ready

    logic [FW-1:0] exp_q [$];
    logic [MW-1:0] mem [0:255];

    logic          prev_stall;
    logic [FW-1:0] prev_flit;
    logic [FW-1:0] mon_exp;

    pe_dma_mc_if #(
        .MEMORY_BUS_WIDTH (MW),
        .FLIT_WIDTH       (FW),
        .NUM_CHANNELS     (NC),
        .LEN_WIDTH        (LW)
    ) bus ();

    pe_dma_mc #(
        .MEMORY_BUS_WIDTH (MW),
        .FLIT_WIDTH       (FW),
        .NUM_CHANNELS     (NC),
        .LEN_WIDTH        (LW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: data appears one cycle after the read strobe; poison
    // otherwise so a capture at the wrong time shows up in the flits.
    always @(posedge clock) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
        else               bus.mem_rdata <= 32'hDEAD_BEEF;
    end

    initial begin
        bus.flit_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       bus.flit_ready = 1'b1;
                1:       bus.flit_ready = ~bus.flit_ready;
                default: bus.flit_ready = 1'b0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: a transfer happens on the coming edge when valid & ready are
    // seen at the falling edge; every transfer pops one expected flit.
    always @(negedge clock) begin
        if (!reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (bus.mem_rd_en) rd_cnt <= rd_cnt + 1;
            if (bus.flit_valid && prev_stall) check("flit_hold", bus.flit_out, prev_flit);
            if (bus.flit_valid && bus.flit_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_flit: got %0h required no flit", bus.flit_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("flit", bus.flit_out, mon_exp);
                end
            end
            prev_stall <= bus.flit_valid && !bus.flit_ready;
            prev_flit  <= bus.flit_out;
        end
    end

    task automatic push_word(input logic [MW-1:0] w);
        exp_q.push_back(w[15:0]);
        exp_q.push_back(w[31:16]);
    endtask

    task automatic cfg_write(input int ch, input logic [MW-1:0] addr, input int len,
                             input logic [NC-1:0] clr);
        bus.cfg_we   = 1'b1;
        bus.cfg_chan = 2'(ch);
        bus.cfg_addr = addr;
        bus.cfg_len  = 16'(len);
        bus.done_clr = clr;
        @(posedge clock);
        #1;
        bus.cfg_we   = 1'b0;
        bus.done_clr = '0;
    endtask

    task automatic clr_done(input logic [NC-1:0] clr);
        bus.done_clr = clr;
        @(posedge clock);
        #1;
        bus.done_clr = '0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((bus.ch_busy != '0 || exp_q.size() != 0) && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout busy=%b pending_flits=%0d required idle", name,
                     bus.ch_busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!bus.flit_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!bus.flit_valid) begin
            checks++;
            failures++;
            $display("FAIL %s: flit_valid low after %0d cycles, required high", name, n);
        end
    endtask

    initial begin
        int lat;
        int base;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hBBBB_AAAA;
        mem[8'h11] = 32'hDDDD_CCCC;
        mem[8'h20] = 32'h1B1B_1A1A;
        mem[8'h30] = 32'h2B2B_2A2A;
        mem[8'h40] = 32'h3B3B_3A3A;

        bus.cfg_we   = 1'b0;
        bus.cfg_chan = '0;
        bus.cfg_addr = '0;
        bus.cfg_len  = '0;
        bus.done_clr = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_flit_valid", bus.flit_valid, 0);
        check("rst_mem_rd_en",  bus.mem_rd_en, 0);
        check("rst_ch_busy",    bus.ch_busy, 0);
        check("rst_ch_done",    bus.ch_done, 0);
        check("rst_cfg_err",    bus.cfg_err, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single channel, two full words
        base = rd_cnt;
        push_word(32'hBBBB_AAAA);
        push_word(32'hDDDD_CCCC);
        cfg_write(0, 32'h10, 4, '0);
        check("t1_cfg_err", bus.cfg_err, 0);
        check("t1_busy_set", bus.ch_busy, 4'b0001);
        wait_valid("t1_valid", lat);
        check("t1_latency", lat, 4);
        wait_idle("t1_idle");
        check("t1_done", bus.ch_done, 4'b0001);
        check("t1_busy_clr", bus.ch_busy, 4'b0000);
        check("t1_reads", rd_cnt - base, 2);
        clr_done(4'b0001);
        check("t1_done_clr", bus.ch_done, 4'b0000);

        // Odd length: partial second word discarded
        base = rd_cnt;
        exp_q.push_back(16'hAAAA);
        exp_q.push_back(16'hBBBB);
        exp_q.push_back(16'hCCCC);
        cfg_write(0, 32'h10, 3, '0);
        wait_idle("t2_idle");
        check("t2_reads", rd_cnt - base, 2);
        check("t2_done", bus.ch_done, 4'b0001);
        repeat (3) @(posedge clock);
        #1;
        check("t2_quiet", bus.flit_valid, 0);
        clr_done(4'b0001);

        // Backpressure: ready toggles every cycle
        ready_mode = 1;
        push_word(32'hBBBB_AAAA);
        push_word(32'hDDDD_CCCC);
        cfg_write(0, 32'h10, 4, '0);
        wait_idle("t3_idle");
        ready_mode = 0;
        check("t3_done", bus.ch_done, 4'b0001);
        clr_done(4'b0001);

        // Write to a busy channel is rejected and does not alter the packet
        base = rd_cnt;
        push_word(32'hBBBB_AAAA);
        push_word(32'hDDDD_CCCC);
        cfg_write(0, 32'h10, 4, '0);
        cfg_write(0, 32'h20, 2, '0);
        check("t4_busy_err", bus.cfg_err, 1);
        @(posedge clock);
        #1;
        check("t4_err_pulse", bus.cfg_err, 0);
        wait_idle("t4_idle");
        check("t4_busy_after", bus.ch_busy, 4'b0000);
        check("t4_reads", rd_cnt - base, 2);
        clr_done(4'b0001);

        // Zero-length descriptor, clear, and set-beats-clear
        cfg_write(2, 32'h30, 0, '0);
        check("t4_len0_err", bus.cfg_err, 0);
        check("t4_len0_done", bus.ch_done, 4'b0100);
        check("t4_len0_busy", bus.ch_busy, 4'b0000);
        clr_done(4'b0100);
        check("t4_len0_clr", bus.ch_done, 4'b0000);
        cfg_write(2, 32'h30, 0, 4'b0100);
        check("t4_set_wins", bus.ch_done, 4'b0100);
        repeat (4) @(posedge clock);
        #1;
        check("t4_len0_noflit", bus.flit_valid, 0);

        // Reset asserted mid-SEND while stalled
        ready_mode = 2;
        cfg_write(0, 32'h10, 4, '0);
        wait_valid("t6_valid", lat);
        check("t6_pre_valid", bus.flit_valid, 1);
        #3 reset = 1'b0;
        #1;
        check("t6_rst_valid",  bus.flit_valid, 0);
        check("t6_rst_rd_en",  bus.mem_rd_en, 0);
        check("t6_rst_busy",   bus.ch_busy, 0);
        check("t6_rst_done",   bus.ch_done, 0);
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b1;
        ready_mode = 0;
        repeat (3) @(posedge clock);
        #1;
        check("t6_idle_valid", bus.flit_valid, 0);
        check("t6_idle_busy",  bus.ch_busy, 0);

        // Round-robin from pointer 0: ch1, ch2, ch3
        push_word(32'h1B1B_1A1A);
        push_word(32'h2B2B_2A2A);
        push_word(32'h3B3B_3A3A);
        cfg_write(1, 32'h20, 2, '0);
        cfg_write(2, 32'h30, 2, '0);
        cfg_write(3, 32'h40, 2, '0);
        check("t5_busy3", bus.ch_busy, 4'b1110);
        wait_idle("t5_idle1");
        check("t5_done1", bus.ch_done, 4'b1110);
        clr_done(4'b1111);
        check("t5_clr", bus.ch_done, 4'b0000);

        // ch1 and ch3 queued while ch2 runs: pointer lands on 3, so ch3 first
        push_word(32'h2B2B_2A2A);
        cfg_write(2, 32'h30, 2, '0);
        wait_valid("t5_valid2", lat);
        cfg_write(1, 32'h20, 2, '0);
        cfg_write(3, 32'h40, 2, '0);
        check("t5_reload_err", bus.cfg_err, 0);
        push_word(32'h3B3B_3A3A);
        push_word(32'h1B1B_1A1A);
        wait_idle("t5_idle2");
        check("t5_done2", bus.ch_done, 4'b1110);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_dma_mc.md
Name: pe_dma_mc

Overview:
- Multi-channel transmit DMA for a processing element. It sits between the CPU configuration path, local memory and the router local port.
- Up to NUM_CHANNELS independent packet descriptors (word address plus length in flits) are queued by the CPU.
- Channels are served one packet at a time with round-robin arbitration. Each memory word is serialised into FLIT_WIDTH flits onto a valid/ready link.
- Successor to the single-channel DMA: adds channel count, flit/bus width ratio and per-channel completion status.

Parameters:
- MEMORY_BUS_WIDTH, 32, memory word and address width; must be an integer multiple of FLIT_WIDTH.
- FLIT_WIDTH, 16, router flit width.
- NUM_CHANNELS, 4, number of descriptor channels, >=2.
- LEN_WIDTH, 16, width of the packet length field in flits.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_we  in  1  descriptor write strobe.
- cfg_chan  in  $clog2(NUM_CHANNELS)  target channel.
- cfg_addr  in  MEMORY_BUS_WIDTH  start word address.
- cfg_len  in  LEN_WIDTH  packet length in flits.
- cfg_err  out  1  one-cycle pulse: write rejected.
- ch_busy  out  NUM_CHANNELS  channel holds a pending or active descriptor.
- ch_done  out  NUM_CHANNELS  sticky completion flags.
- done_clr  in  NUM_CHANNELS  clears the matching ch_done bits.
- mem_rd_en  out  1  memory read request.
- mem_addr  out  MEMORY_BUS_WIDTH  read word address.
- mem_rdata  in  MEMORY_BUS_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- flit_out  out  FLIT_WIDTH  flit to router.
- flit_valid  out  1  flit_out valid.
- flit_ready  in  1  router accepts flit.

Behaviour:
- Reset (reset=0, async): FSM=IDLE; all outputs 0; rr pointer=0; all descriptors cleared.
- RATIO = MEMORY_BUS_WIDTH/FLIT_WIDTH. Flit order within a word: least-significant slice first.
- Descriptor write, cfg_we=1:
  - Target channel not busy and cfg_len!=0: latch addr/len, set ch_busy next cycle.
  - Target busy: ignore the write, pulse cfg_err.
  - cfg_len==0: set ch_done, ch_busy stays 0, no cfg_err.
- ch_done clear: done_clr bits clear ch_done. If a set and a clear hit the same cycle, set wins.
- FSM states:
  - IDLE: if any ch_busy, go to ARB.
  - ARB: grant the first busy channel at or after the rr pointer (wrap modulo NUM_CHANNELS); load remaining=len and addr; go to READ.
  - READ: mem_rd_en=1 for one cycle, mem_addr=current addr; go to WAIT.
  - WAIT: capture mem_rdata into the shift register; slice=0; go to SEND.
  - SEND: flit_valid=1, flit_out=slice.
    - A transfer occurs only on a cycle with flit_valid & flit_ready. flit_out must hold stable while flit_valid=1 & flit_ready=0.
    - Each transfer: remaining-=1, slice+=1.
    - remaining reaches 0: go to DONE; any partial word is discarded.
    - Else slice reaches RATIO: addr+=1, go to READ.
  - DONE: clear the channel's ch_busy, set its ch_done, rr pointer=grant+1 (wrap); go to IDLE.
- Latency:
  - cfg_we to first flit_valid: 4 cycles when idle (busy set, IDLE->ARB, READ, WAIT, then SEND).
  - Per-word gap: 2 bubble cycles (READ, WAIT).
- No pre-emption: a granted packet runs to completion.
- Address increments wrap modulo 2^MEMORY_BUS_WIDTH.
- Reset mid-packet aborts immediately: no further flits, descriptors lost.

Decomposition:
- Shared package pe_dma_pkg:
  - FSM state enum (IDLE, ARB, READ, WAIT, SEND, DONE).
  - Descriptor struct {addr, len}.
  - RATIO and channel-index width functions.
- Sub-module rr_arbiter (NUM_CHANNELS req vector + pointer -> one-hot grant, combinational). The rest lives in pe_dma_mc.

Test Plan:
- Single channel, ch0 addr=0x10, len=4, RATIO=2, mem[0x10]=0xBBBBAAAA, mem[0x11]=0xDDDDCCCC, ready=1 -> flits AAAA,BBBB,CCCC,DDDD; first valid 4 cycles after cfg_we; ch_done[0]=1, ch_busy[0]=0.
- Odd length len=3 same data -> flits AAAA,BBBB,CCCC only; exactly 2 mem reads; ch_done[0] set.
- Backpressure: flit_ready toggles 0/1 each cycle -> flit_out stable while stalled; same 4 flits, no duplicates or drops.
- Round-robin: ch1, ch2 and ch3 all loaded in one idle window, rr=0 -> service order 1,2,3. Then reload ch1 and ch3 while ch2 runs -> order ch3 before ch1.
- Busy write to ch0 during its transfer -> cfg_err pulse, descriptor unchanged. len=0 write to ch2 -> ch_done[2]=1 with no flits; done_clr[2] clears it; simultaneous set+clr leaves ch_done=1.
- Assert reset mid-SEND -> flit_valid, mem_rd_en, ch_busy, ch_done all 0 asynchronously; after release the block is idle and accepts a new descriptor.
